// File: rtl/text_mode_ctrl.sv
// text_mode_ctrl: character-cell text renderer.
// Owns the COLS x ROWS text buffer and drives an external combinational 8x16 font ROM.
// The pixel pipeline has a latency of 2 cycles, with sync and DE delay-matched.
// Host writes use a valid/ready handshake, and a sequencer fills the buffer with FILL_CHAR.
// Optional blinking cursor: define CURSOR_EN.
module text_mode_ctrl #(
    parameter int unsigned COLS      = 80,
    parameter int unsigned ROWS      = 30,
    parameter int unsigned ADDR_W    = 12,
    parameter logic [7:0]  FILL_CHAR = 8'h20
`ifdef CURSOR_EN
    ,
    parameter int unsigned BLINK_FRAMES = 16
`endif
) (
    input  logic              iClk,
    input  logic              inRst,
    input  logic [10:0]       iX,
    input  logic [9:0]        iY,
    input  logic              iDe,
    input  logic              iHs,
    input  logic              iVs,
    output logic              oPixel,
    output logic              oDe,
    output logic              oHs,
    output logic              oVs,
    output logic [7:0]        oFontChar,
    output logic [3:0]        oFontRow,
    input  logic [7:0]        iFontLine,
    input  logic              iWrValid,
    output logic              oWrReady,
    input  logic [ADDR_W-1:0] iWrAddr,
    input  logic [7:0]        iWrData,
    input  logic              iClear,
    output logic              oBusy
`ifdef CURSOR_EN
    ,
    input  logic [ADDR_W-1:0] iCurAddr,
    input  logic              iCurEn
`endif
);

    localparam int unsigned       CELLS = COLS * ROWS;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(CELLS - 1);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e            state, state_next;
    logic [ADDR_W-1:0] cnt, cnt_next;
    logic              busy_next, ready_next;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    logic [7:0]        mem [CELLS];
    logic [ADDR_W-1:0] rd_index;
    logic              in_range;

    logic [2:0]        xbit1;
    logic              de1, hs1, vs1, inrange1;
    logic              pix_bit;

    // Stage 0: map the pixel position to a cell index and flag out-of-screen positions.
    always_comb begin
        rd_index = ADDR_W'(32'(iY[9:4]) * COLS + 32'(iX[10:3]));
        in_range = (32'(iX) < COLS * 8) && (32'(iY) < ROWS * 16);
    end

    // Text buffer write port (host or clear). Contents are not reset.
    always_ff @(posedge iClk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Synchronous read-first display port. Off-screen cells read as character 0.
    always_ff @(posedge iClk or negedge inRst) begin
        if (!inRst) begin
            oFontChar <= '0;
        end else if (in_range) begin
            oFontChar <= mem[rd_index];
        end else begin
            oFontChar <= '0;
        end
    end

    // Stage 1: carry the glyph row, pixel column and timing alongside the RAM read.
    always_ff @(posedge iClk or negedge inRst) begin
        if (!inRst) begin
            oFontRow <= '0;
            xbit1    <= '0;
            de1      <= 1'b0;
            hs1      <= 1'b0;
            vs1      <= 1'b0;
            inrange1 <= 1'b0;
        end else begin
            oFontRow <= iY[3:0];
            xbit1    <= iX[2:0];
            de1      <= iDe;
            hs1      <= iHs;
            vs1      <= iVs;
            inrange1 <= in_range;
        end
    end

`ifdef CURSOR_EN
    localparam int unsigned FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FC_W-1:0] frame_cnt;
    logic            phase;
    logic            cur_hit;
    logic            cur1;

    // Cursor covers the bottom two glyph rows of the addressed cell while the blink phase is on.
    always_comb begin
        cur_hit = iCurEn && phase && (rd_index == iCurAddr) && (iY[3:1] == 3'b111);
    end

    // Cursor hit delay-matched to stage 1.
    always_ff @(posedge iClk or negedge inRst) begin
        if (!inRst) begin
            cur1 <= 1'b0;
        end else begin
            cur1 <= cur_hit;
        end
    end

    // Blink timer: count frames on the rising edge of the delayed vsync.
    always_ff @(posedge iClk or negedge inRst) begin
        if (!inRst) begin
            frame_cnt <= '0;
            phase     <= 1'b0;
        end else if (vs1 && !oVs) begin
            if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
                frame_cnt <= '0;
                phase     <= ~phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Select the glyph bit, with bit 7 leftmost, and invert it under the cursor.
    always_comb begin
        pix_bit = iFontLine[~xbit1] ^ cur1;
    end
`else
    // Select the glyph bit; bit 7 is the leftmost pixel.
    always_comb begin
        pix_bit = iFontLine[~xbit1];
    end
`endif

    // Stage 2: register the final pixel and the delayed timing signals.
    always_ff @(posedge iClk or negedge inRst) begin
        if (!inRst) begin
            oPixel <= 1'b0;
            oDe    <= 1'b0;
            oHs    <= 1'b0;
            oVs    <= 1'b0;
        end else begin
            oPixel <= pix_bit & de1 & inrange1;
            oDe    <= de1;
            oHs    <= hs1;
            oVs    <= vs1;
        end
    end

    // Clear FSM state register, with registered busy and ready outputs.
    always_ff @(posedge iClk or negedge inRst) begin
        if (!inRst) begin
            state    <= StIdle;
            cnt      <= '0;
            oBusy    <= 1'b0;
            oWrReady <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            oBusy    <= busy_next;
            oWrReady <= ready_next;
        end
    end

    // Clear FSM next state: one cell per cycle, returning to idle after the last cell.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            StIdle: begin
                if (iClear) begin
                    state_next = StClear;
                    cnt_next   = '0;
                end
            end
            StClear: begin
                cnt_next = cnt + 1'b1;
                if (cnt == LAST) begin
                    state_next = StIdle;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = StIdle;
                cnt_next   = '0;
            end
        endcase
    end

    // Clear FSM outputs: handshake flags and buffer write-port arbitration.
    always_comb begin
        busy_next  = (state_next == StClear);
        ready_next = (state_next == StIdle);
        wr_en      = 1'b0;
        wr_addr    = iWrAddr;
        wr_data    = iWrData;
        if (state == StClear) begin
            wr_en   = 1'b1;
            wr_addr = cnt;
            wr_data = FILL_CHAR;
        end else if (iWrValid && oWrReady && (32'(iWrAddr) < CELLS)) begin
            // An out-of-range address still completes the handshake, but nothing is written.
            wr_en = 1'b1;
        end
    end

endmodule

// File: tb/tb_text_mode_ctrl.sv
// Scoreboard bench for text_mode_ctrl: stimulus queues expected values tagged with the cycle
// in which they must appear. A negedge monitor pops and compares them.
module tb_text_mode_ctrl;

    localparam int K_PIX   = 0;
    localparam int K_CHAR  = 1;
    localparam int K_ROW   = 2;
    localparam int K_DE    = 3;
    localparam int K_HS    = 4;
    localparam int K_VS    = 5;
    localparam int K_BUSY  = 6;
    localparam int K_READY = 7;

    typedef struct {
        int         due;
        int         kind;
        logic [7:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        inRst;
    logic [10:0] iX;
    logic [9:0]  iY;
    logic        iDe, iHs, iVs;
    logic        oPixel, oDe, oHs, oVs;
    logic [7:0]  oFontChar;
    logic [3:0]  oFontRow;
    logic [7:0]  iFontLine;
    logic        iWrValid;
    logic        oWrReady;
    logic [11:0] iWrAddr;
    logic [7:0]  iWrData;
    logic        iClear;
    logic        oBusy;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        sbq[$];
    exp_t        mon_e;
    logic [7:0]  mon_a;
    logic [7:0]  model [2400];
    bit          known [2400];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Asymmetric font ROM model, so that bit-order errors change the output.
    function automatic logic [7:0] rom(input logic [7:0] c, input logic [3:0] r);
        return c ^ {r, 4'hA};
    endfunction

    assign iFontLine = rom(oFontChar, oFontRow);

    text_mode_ctrl dut (
        .iClk      (clk),
        .inRst     (inRst),
        .iX        (iX),
        .iY        (iY),
        .iDe       (iDe),
        .iHs       (iHs),
        .iVs       (iVs),
        .oPixel    (oPixel),
        .oDe       (oDe),
        .oHs       (oHs),
        .oVs       (oVs),
        .oFontChar (oFontChar),
        .oFontRow  (oFontRow),
        .iFontLine (iFontLine),
        .iWrValid  (iWrValid),
        .oWrReady  (oWrReady),
        .iWrAddr   (iWrAddr),
        .iWrData   (iWrData),
        .iClear    (iClear),
        .oBusy     (oBusy)
    );

    function automatic string kname(input int k);
        case (k)
            K_PIX:   return "pixel";
            K_CHAR:  return "font_char";
            K_ROW:   return "font_row";
            K_DE:    return "de";
            K_HS:    return "hs";
            K_VS:    return "vs";
            K_BUSY:  return "busy";
            default: return "wr_ready";
        endcase
    endfunction

    function automatic logic [7:0] actual(input int k);
        case (k)
            K_PIX:   return {7'd0, oPixel};
            K_CHAR:  return oFontChar;
            K_ROW:   return {4'd0, oFontRow};
            K_DE:    return {7'd0, oDe};
            K_HS:    return {7'd0, oHs};
            K_VS:    return {7'd0, oVs};
            K_BUSY:  return {7'd0, oBusy};
            default: return {7'd0, oWrReady};
        endcase
    endfunction

    // Insert into the queue in due-cycle order.
    function automatic void push(input int due, input int kind, input logic [7:0] val);
        exp_t e;
        int   i;
        e.due  = due;
        e.kind = kind;
        e.val  = val;
        i = sbq.size();
        while (i > 0 && sbq[i-1].due > due) i--;
        sbq.insert(i, e);
    endfunction

    // Monitor: compare every expectation due in this cycle.
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            mon_e = sbq.pop_front();
            mon_a = actual(mon_e.kind);
            n_checks = n_checks + 1;
            if (mon_e.due != cyc || mon_a !== mon_e.val) begin
                n_fail = n_fail + 1;
                $display("FAIL %s cycle %0d (due %0d): got %h, expected %h",
                         kname(mon_e.kind), cyc, mon_e.due, mon_a, mon_e.val);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic step(input int x, input int y, input bit de, input bit hs, input bit vs);
        bit         rng;
        bit         kn;
        int         idx;
        int         xb;
        logic [3:0] row;
        logic [7:0] ch;
        logic [7:0] line;
        @(posedge clk);
        #1;
        iX  = 11'(x);
        iY  = 10'(y);
        iDe = de;
        iHs = hs;
        iVs = vs;
        rng = (x < 640) && (y < 480);
        idx = (y / 16) * 80 + x / 8;
        row = 4'(y % 16);
        xb  = x % 8;
        if (rng) begin
            kn = known[idx];
            ch = model[idx];
        end else begin
            kn = 1'b1;
            ch = 8'h00;
        end
        line = rom(ch, row);
        push(cyc + 1, K_ROW, {4'd0, row});
        push(cyc + 2, K_DE, {7'd0, de});
        push(cyc + 2, K_HS, {7'd0, hs});
        push(cyc + 2, K_VS, {7'd0, vs});
        if (kn) begin
            push(cyc + 1, K_CHAR, ch);
            push(cyc + 2, K_PIX, {7'd0, de & rng & line[7-xb]});
        end
    endtask

    task automatic host_write(input int addr, input logic [7:0] data);
        int guard;
        guard = 0;
        @(posedge clk);
        #1;
        iWrValid = 1'b1;
        iWrAddr  = 12'(addr);
        iWrData  = data;
        while (!oWrReady && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        push(cyc, K_READY, 8'd1);
        @(posedge clk);
        #1;
        iWrValid = 1'b0;
        if (addr < 2400) begin
            model[addr] = data;
            known[addr] = 1'b1;
        end
    endtask

    // Run a clear. A negative abort_at runs it to completion; otherwise reset is
    // asserted after abort_at busy cycles.
    task automatic run_clear(input bit with_write, input int abort_at);
        int c1;
        int n;
        @(posedge clk);
        #1;
        push(cyc, K_READY, 8'd1);
        iClear = 1'b1;
        if (with_write) begin
            iWrValid = 1'b1;
            iWrAddr  = 12'd5;
            iWrData  = 8'h7F;
        end
        @(posedge clk);
        #1;
        iClear   = 1'b0;
        iWrValid = 1'b0;
        c1 = cyc;
        n  = (abort_at < 0) ? 2400 : abort_at;
        for (int i = 0; i < n; i++) begin
            push(c1 + i, K_BUSY, 8'd1);
            push(c1 + i, K_READY, 8'd0);
        end
        if (abort_at < 0) begin
            push(c1 + 2400, K_BUSY, 8'd0);
            push(c1 + 2400, K_READY, 8'd1);
            // A clear request while clearing must be ignored.
            wait_cyc(c1 + 500);
            iClear = 1'b1;
            @(posedge clk);
            #1;
            iClear = 1'b0;
            wait_cyc(c1 + 2401);
            for (int a = 0; a < 2400; a++) begin
                model[a] = 8'h20;
                known[a] = 1'b1;
            end
        end else begin
            wait_cyc(c1 + abort_at);
            inRst = 1'b0;
            push(cyc, K_BUSY, 8'd0);
            push(cyc, K_READY, 8'd0);
            repeat (3) @(posedge clk);
            #1;
            inRst = 1'b1;
            push(cyc, K_BUSY, 8'd0);
            push(cyc, K_READY, 8'd0);
            push(cyc + 1, K_READY, 8'd1);
            wait_cyc(cyc + 2);
            for (int a = 0; a < 2400; a++) known[a] = 1'b0;
        end
    endtask

    initial begin
        inRst    = 1'b0;
        iX       = '0;
        iY       = '0;
        iDe      = 1'b0;
        iHs      = 1'b0;
        iVs      = 1'b0;
        iWrValid = 1'b0;
        iWrAddr  = '0;
        iWrData  = '0;
        iClear   = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        inRst = 1'b1;

        n_checks = n_checks + 8;
        if (oPixel !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset pixel: got %b", oPixel);
        end
        if (oDe !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset de: got %b", oDe);
        end
        if (oHs !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset hs: got %b", oHs);
        end
        if (oVs !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset vs: got %b", oVs);
        end
        if (oFontChar !== 8'h00) begin
            n_fail = n_fail + 1;
            $display("FAIL reset font_char: got %h", oFontChar);
        end
        if (oFontRow !== 4'h0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset font_row: got %h", oFontRow);
        end
        if (oBusy !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset busy: got %b", oBusy);
        end
        if (oWrReady !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset wr_ready: got %b", oWrReady);
        end

        for (int k = K_PIX; k <= K_READY; k++) push(cyc, k, 8'd0);
        push(cyc + 1, K_READY, 8'd1);

        // Glyph 'A' row 0, pixels 0..7: expected pixel bits are 0x41 ^ 0x0A = 0x4B, MSB first.
        host_write(0, 8'h41);
        for (int x = 0; x < 8; x++) step(x, 0, 1'b1, 1'b0, 1'b0);

        // Cell (1,1) at index 81, glyph row 5, with the sync and DE delay.
        host_write(81, 8'h42);
        step(8, 21, 1'b1, 1'b1, 1'b0);
        step(11, 21, 1'b1, 1'b0, 1'b1);
        step(12, 21, 1'b0, 1'b1, 1'b1);
        step(13, 21, 1'b1, 1'b0, 1'b0);

        // Off-screen positions.
        step(640, 0, 1'b1, 1'b0, 1'b0);
        step(0, 480, 1'b1, 1'b0, 1'b0);
        step(2047, 1023, 1'b1, 1'b0, 1'b0);

        // An out-of-range write completes the handshake and leaves the buffer alone.
        host_write(2400, 8'hEE);
        step(1, 0, 1'b1, 1'b0, 1'b0);
        step(9, 16, 1'b1, 1'b0, 1'b0);

        // Full clear with a simultaneous write, then verify every cell.
        run_clear(1'b1, -1);
        for (int r = 0; r < 30; r++) begin
            for (int c = 0; c < 80; c++) begin
                step(c * 8 + (c % 8), r * 16 + (r % 16), 1'b1, 1'b0, 1'b0);
            end
        end

        // Reset in the middle of a clear, then a complete clear.
        run_clear(1'b0, 1000);
        run_clear(1'b0, -1);
        host_write(2399, 8'h5A);
        step(639, 479, 1'b1, 1'b0, 1'b0);
        step(323, 83, 1'b1, 1'b0, 1'b0);

        wait_cyc(cyc + 4);
        if (n_fail != 0) begin
            $display("TEST FAILED");
        end else begin
            $display("TEST PASSED");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/text_mode_ctrl.md
Name: text_mode_ctrl

Overview:
- Character-cell text renderer for the display path; owns the on-chip text buffer (COLS x ROWS bytes) and sequences the external combinational font ROM (8x16 glyphs).
- Converts pixel coordinates from the video timing generator into a character fetch, then a font row lookup, then a pixel bit. Sync and data-enable are delay-matched.
- Provides a host write port with valid/ready handshake and a hardware buffer-clear sequencer.

Parameters:
- COLS, 80, text columns (cell width 8 px)
- ROWS, 30, text rows (cell height 16 px)
- ADDR_W, 12, text buffer address width; must satisfy 2^ADDR_W >= COLS*ROWS
- FILL_CHAR, 8'h20, byte written by the clear sequencer

Ports:
- iClk  in  1  system/pixel clock; single clock domain
- inRst  in  1  asynchronous active-low reset
- iX  in  11  pixel column from timing generator
- iY  in  10  pixel row from timing generator
- iDe  in  1  active-video enable
- iHs  in  1  hsync, passed through with delay
- iVs  in  1  vsync, passed through with delay
- oPixel  out  1  rendered pixel (1 = foreground)
- oDe  out  1  delayed iDe
- oHs  out  1  delayed iHs
- oVs  out  1  delayed iVs
- oFontChar  out  8  character code to font ROM
- oFontRow  out  4  glyph row to font ROM
- iFontLine  in  8  font ROM row bitmap; bit 7 is the leftmost pixel; combinational return
- iWrValid  in  1  host write request
- oWrReady  out  1  host write may be accepted
- iWrAddr  in  ADDR_W  text buffer address (row*COLS + col)
- iWrData  in  8  character code
- iClear  in  1  start buffer clear (sampled as level in IDLE)
- oBusy  out  1  clear in progress

Behaviour:
- Clocking and reset: one clock (iClk). Reset is asynchronous and active-low (inRst). All outputs below are registered.
- Reset values: oPixel=0, oDe=0, oHs=0, oVs=0, oFontChar=0, oFontRow=0, oBusy=0, oWrReady=0, FSM=IDLE.
- oWrReady goes to 1 on the first clock edge after reset release, in IDLE.
- Text buffer: COLS*ROWS x 8 RAM with one synchronous read port (display) and one write port (host/clear). Contents are not reset.
- Read-during-write to the same address is read-first: the display sees the old byte.
- Pixel pipeline, latency 2 cycles (inputs at cycle N produce oPixel/oDe/oHs/oVs at N+2):
  - Stage 0 (cycle N): index = (iY>>4)*COLS + (iX>>3); RAM read issued. iY[3:0], iX[2:0], iDe, iHs, iVs and an in-range flag are registered.
  - In-range means iX < COLS*8 and iY < ROWS*16. Out of range suppresses the read; the character is forced to 0.
  - Stage 1 (cycle N+1): oFontChar = RAM data (or 0 if out of range); oFontRow = registered iY[3:0].
  - Stage 2 (cycle N+2): oPixel = iFontLine[7 - xbit] & de1 & inrange1. oDe/oHs/oVs are stage-1 values registered.
  - The pipeline runs every cycle, with no stalls. When iDe=0, oPixel=0.
- Host write:
  - A write occurs on iWrValid & oWrReady.
  - If iWrAddr >= COLS*ROWS, the write is accepted (handshake completes) but dropped.
  - Data is visible to display reads from the next cycle.
- Clear FSM:
  - IDLE: oWrReady=1, oBusy=0. If iClear=1, go to CLEAR next cycle with cnt=0.
  - If iClear and an accepted write occur in the same IDLE cycle, the write happens first; the clear overwrites it later.
  - CLEAR: oWrReady=0, oBusy=1. Writes FILL_CHAR to address cnt each cycle; cnt increments.
  - At cnt = COLS*ROWS-1, write that address and go to IDLE. The clear takes exactly COLS*ROWS cycles.
  - iClear during CLEAR is ignored.
- Reset asserted mid-clear forces IDLE immediately; the buffer is left partially cleared (undefined).

Optional Feature:
- Macro CURSOR_EN.
- Defined:
  - Adds ports iCurAddr (in, ADDR_W) and iCurEn (in, 1), plus parameter BLINK_FRAMES (default 16).
  - A frame counter increments on each registered iVs rising edge and wraps at BLINK_FRAMES-1; the blink phase toggles on each wrap.
  - When iCurEn=1, the phase is on, the stage-0 index equals iCurAddr and the glyph row is 14 or 15, the stage-2 pixel is inverted (in range and iDe only).
  - The counter and phase reset to 0.
- Undefined: the ports, parameter and logic are absent; behaviour is as above.

Test Plan:
- Reset release: hold inRst=0 for 5 cycles, then release -> all outputs 0. oWrReady=1 one edge later.
- Write addr 0 = 8'h41, then drive iX=0..7, iY=0, iDe=1 -> oFontChar=8'h41 at N+1. oPixel at N+2 equals the ROM model 'A' row-0 bits, MSB first.
- Write addr COLS+1 (81) = 8'h42, then drive iX=8, iY=21 -> oFontChar=8'h42 and oFontRow=5. oHs/oVs/oDe are delayed exactly 2 cycles.
- iX=640 or iY=480 with iDe=1 -> oPixel=0 and oFontChar=0. Write to addr 2400 -> handshake completes, RAM unchanged.
- Pulse iClear with a simultaneous write (addr 5 = 8'h7F) -> oBusy=1 for exactly 2400 cycles and oWrReady=0 throughout. All addresses then read 8'h20, including addr 5.
- Assert inRst at clear cycle 1000 -> oBusy=0 immediately. After release, a new clear runs the full 2400 cycles.
